// File: rtl/beat_pkg.sv
// Shared types and constants for the beat sequencer and its tempo divider.
package beat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SPD_X1    = 2'd0,
    SPD_X2    = 2'd1,
    SPD_X4    = 2'd2,
    SPD_XHALF = 2'd3
  } speed_e;

  localparam int DEF_SLOT_BEATS = 4;
  localparam int SONG_BEATS     = 64;
  localparam int IBEAT_W        = 12;

endpackage

// File: rtl/beat_tick_gen.sv
// Tempo divider: emits a one-cycle tick every P running cycles, P chosen by speed.
module beat_tick_gen
  import beat_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BEAT_BASE_HZ = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int BASE  = CLK_FREQ / BEAT_BASE_HZ;
  localparam int CNT_W = $clog2(2 * BASE);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;

  always_comb begin
    limit = CNT_W'(BASE - 1);
    case (speed_e'(speed))
      SPD_X2:    limit = CNT_W'(BASE / 2 - 1);
      SPD_X4:    limit = CNT_W'(BASE / 4 - 1);
      SPD_XHALF: limit = CNT_W'(2 * BASE - 1);
      default:   limit = CNT_W'(BASE - 1);
    endcase
  end

  // ">=" lets a mid-period speed-up fire on the very next cycle instead of wrapping
  assign tick = run && (count >= limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Playback controller: turns play/pause/stop pulses into a tempo-driven beat index
// with loop mode and optional skipping of muted note slots.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BEAT_BASE_HZ = 8,
  parameter int SLOT_BEATS   = DEF_SLOT_BEATS,
  parameter int NUM_SLOTS    = SONG_BEATS / DEF_SLOT_BEATS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 play_pulse,
  input  logic                 pause_pulse,
  input  logic                 stop_pulse,
  input  logic                 loop_en,
  input  logic                 skip_muted,
  input  logic [NUM_SLOTS-1:0] switch,
  input  logic [1:0]           speed,
  output logic [IBEAT_W-1:0]   ibeat,
  output logic                 en,
  output logic                 playing,
  output logic                 done
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  typedef logic [SLOT_W:0] sidx_t;

  state_e               state_q, state_d;
  logic [IBEAT_W-1:0]   ibeat_q, ibeat_d;
  logic                 done_d;
  logic                 en_q, playing_q, done_q;
  logic                 run, clear, tick;
  logic [IBEAT_W-1:0]   cur_slot, phase;
  sidx_t                start_slot, next_slot;
  logic                 start_ok, next_ok;

  // Lowest slot >= from that may play; NUM_SLOTS means none left. Slot k maps to switch[NUM_SLOTS-1-k].
  function automatic sidx_t find_slot(input sidx_t from, input logic skip,
                                      input logic [NUM_SLOTS-1:0] sw);
    sidx_t res;
    res = sidx_t'(NUM_SLOTS);
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if ((k >= int'(from)) && (!skip || sw[NUM_SLOTS-1-k])) res = sidx_t'(k);
    end
    return res;
  endfunction

  function automatic logic [IBEAT_W-1:0] slot_base(input sidx_t s);
    return IBEAT_W'(int'(s) * SLOT_BEATS);
  endfunction

  assign cur_slot   = ibeat_q / IBEAT_W'(SLOT_BEATS);
  assign phase      = ibeat_q % IBEAT_W'(SLOT_BEATS);
  assign start_slot = find_slot('0, skip_muted, switch);
  assign next_slot  = find_slot(sidx_t'(cur_slot + IBEAT_W'(1)), skip_muted, switch);
  assign start_ok   = (start_slot != sidx_t'(NUM_SLOTS));
  assign next_ok    = (next_slot != sidx_t'(NUM_SLOTS));

  // A pause or stop arriving this cycle freezes the count so resume picks up exactly where it left
  assign run   = (state_q == PLAY) && !stop_pulse && !pause_pulse;
  assign clear = (state_d == IDLE);

  beat_tick_gen #(
    .CLK_FREQ    (CLK_FREQ),
    .BEAT_BASE_HZ(BEAT_BASE_HZ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clear(clear),
    .speed(speed),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    ibeat_d = ibeat_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop_pulse && !pause_pulse && play_pulse && start_ok) begin
          state_d = PLAY;
          ibeat_d = slot_base(start_slot);
        end
      end
      PLAY: begin
        if (stop_pulse) begin
          state_d = IDLE;
          ibeat_d = '0;
        end else if (pause_pulse) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (phase != IBEAT_W'(SLOT_BEATS - 1)) begin
            ibeat_d = ibeat_q + IBEAT_W'(1);
          end else if (next_ok) begin
            ibeat_d = slot_base(next_slot);
          end else if (loop_en && start_ok) begin
            ibeat_d = slot_base(start_slot);
          end else begin
            state_d = IDLE;
            ibeat_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (stop_pulse) begin
          state_d = IDLE;
          ibeat_d = '0;
        end else if (!pause_pulse && play_pulse) begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d = IDLE;
        ibeat_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ibeat_q   <= '0;
      en_q      <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ibeat_q   <= ibeat_d;
      en_q      <= (state_d == PLAY);
      playing_q <= (state_d != IDLE);
      done_q    <= done_d;
    end
  end

  assign ibeat   = ibeat_q;
  assign en      = en_q;
  assign playing = playing_q;
  assign done    = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: stimulus queues timestamped expected outputs,
// a negedge monitor pops them whenever outputs change or an expected sample falls due.
module tb_beat_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        play_pulse, pause_pulse, stop_pulse;
  logic        loop_en, skip_muted;
  logic [15:0] switch;
  logic [1:0]  speed;
  logic [11:0] ibeat;
  logic        en, playing, done;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int          cyc;
    logic [11:0] ibeat;
    logic        en;
    logic        playing;
    logic        done;
  } exp_t;

  exp_t q[$];

  beat_sequencer #(
    .CLK_FREQ    (160),
    .BEAT_BASE_HZ(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play_pulse (play_pulse),
    .pause_pulse(pause_pulse),
    .stop_pulse (stop_pulse),
    .loop_en    (loop_en),
    .skip_muted (skip_muted),
    .switch     (switch),
    .speed      (speed),
    .ibeat      (ibeat),
    .en         (en),
    .playing    (playing),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input int b, input logic e, input logic p, input logic d);
    exp_t x;
    x.cyc = c;
    x.ibeat = 12'(b);
    x.en = e;
    x.playing = p;
    x.done = d;
    q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic applyStimulus(input logic p, input logic ps, input logic s);
    play_pulse  = p;
    pause_pulse = ps;
    stop_pulse  = s;
    step(1);
    play_pulse  = 1'b0;
    pause_pulse = 1'b0;
    stop_pulse  = 1'b0;
  endtask

  task automatic checkOutput(input exp_t x);
    compared++;
    if (x.cyc != cyc || x.ibeat !== ibeat || x.en !== en || x.playing !== playing || x.done !== done) begin
      mismatched++;
      $display("[TB] FAIL out@%0d: got cyc=%0d ibeat=%0d en=%b playing=%b done=%b, want cyc=%0d ibeat=%0d en=%b playing=%b done=%b",
               x.cyc, cyc, ibeat, en, playing, done, x.cyc, x.ibeat, x.en, x.playing, x.done);
    end
  endtask

  logic [14:0] prev = 'x;
  logic [14:0] cur_v;
  logic        changed;

  // Monitor: an output change, or an expectation whose cycle has arrived, consumes one entry
  always @(negedge clk) begin
    if (cyc > 0) begin
      cur_v   = {ibeat, en, playing, done};
      changed = (cur_v !== prev);
      prev    = cur_v;
      if (changed && q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_change cyc=%0d: got ibeat=%0d en=%b playing=%b done=%b, want no change",
                 cyc, ibeat, en, playing, done);
      end else if (q.size() > 0 && (changed || q[0].cyc <= cyc)) begin
        checkOutput(q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    mismatched++;
    $display("[TB] FAIL watchdog: got time limit reached, want end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int e;
    rst = 1'b1;
    play_pulse = 1'b0; pause_pulse = 1'b0; stop_pulse = 1'b0;
    loop_en = 1'b0; skip_muted = 1'b0; switch = 16'hFFFF; speed = 2'b00;
    push_exp(1, 0, 0, 0, 0);
    step(3);
    rst = 1'b0;

    $display("[TB] play, tempo x1 -> x2 -> x0.5");
    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    push_exp(e + 20, 1, 1, 1, 0);
    push_exp(e + 30, 2, 1, 1, 0);
    push_exp(e + 70, 3, 1, 1, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 20); speed = 2'b01;
    step_to(e + 30); speed = 2'b11;
    step_to(e + 75);
    push_exp(cyc + 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    speed = 2'b00;

    $display("[TB] full song, no loop");
    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    for (int k = 1; k < 64; k++) push_exp(e + 20 * k, k, 1, 1, 0);
    push_exp(e + 1280, 0, 0, 0, 1);
    push_exp(e + 1281, 0, 0, 0, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 1283);

    $display("[TB] full song, loop at x4");
    loop_en = 1'b1; speed = 2'b10;
    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    for (int k = 1; k < 64; k++) push_exp(e + 5 * k, k, 1, 1, 0);
    push_exp(e + 320, 0, 1, 1, 0);
    push_exp(e + 325, 1, 1, 1, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 327);
    push_exp(cyc + 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    loop_en = 1'b0; speed = 2'b00;

    $display("[TB] pause mid-period and resume");
    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    for (int k = 1; k <= 7; k++) push_exp(e + 20 * k, k, 1, 1, 0);
    push_exp(e + 146, 7, 0, 1, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 145);
    applyStimulus(0, 1, 0);
    step(100);
    e = cyc + 1;
    push_exp(e, 7, 1, 1, 0);
    push_exp(e + 15, 8, 1, 1, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 17);
    push_exp(cyc + 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);

    $display("[TB] skip muted slots");
    skip_muted = 1'b1; switch = 16'h8001;
    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    for (int k = 1; k <= 3; k++) push_exp(e + 20 * k, k, 1, 1, 0);
    for (int k = 0; k <= 3; k++) push_exp(e + 80 + 20 * k, 60 + k, 1, 1, 0);
    push_exp(e + 160, 0, 0, 0, 1);
    push_exp(e + 161, 0, 0, 0, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 163);

    switch = 16'h0100; speed = 2'b10;
    e = cyc + 1;
    push_exp(e, 28, 1, 1, 0);
    for (int k = 1; k <= 3; k++) push_exp(e + 5 * k, 28 + k, 1, 1, 0);
    push_exp(e + 20, 0, 0, 0, 1);
    push_exp(e + 21, 0, 0, 0, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 23);

    switch = 16'h0000;
    push_exp(cyc + 2, 0, 0, 0, 0);
    applyStimulus(1, 0, 0);
    step(3);
    skip_muted = 1'b0; switch = 16'hFFFF;

    $display("[TB] stop and reset");
    push_exp(cyc + 2, 0, 0, 0, 0);
    applyStimulus(1, 0, 1);
    step(2);
    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    for (int k = 1; k <= 30; k++) push_exp(e + 5 * k, k, 1, 1, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 150);
    push_exp(cyc + 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    step(2);

    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    for (int k = 1; k <= 3; k++) push_exp(e + 5 * k, k, 1, 1, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 17);
    push_exp(e + 18, 0, 0, 0, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    push_exp(e + 5, 1, 1, 1, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 7);
    push_exp(cyc + 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    speed = 2'b00;

    $display("[TB] speed-up mid-period");
    e = cyc + 1;
    push_exp(e, 0, 1, 1, 0);
    push_exp(e + 13, 1, 1, 1, 0);
    push_exp(e + 18, 2, 1, 1, 0);
    push_exp(e + 23, 3, 1, 1, 0);
    applyStimulus(1, 0, 0);
    step_to(e + 12); speed = 2'b10;
    step_to(e + 25);
    push_exp(cyc + 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    speed = 2'b00;

    step(5);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
